// File: rtl/top_k_pkg.sv
// Shared definitions for the top-k sorter: stream field positions, FSM states, parser opcodes.
package top_k_pkg;

    localparam int unsigned K_MAX_DEF = 16;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned TDATA_W   = DATA_W + 2;

    localparam int unsigned CLR_BIT   = 33;
    localparam int unsigned LAST_BIT  = 32;
    localparam int unsigned K_LSB     = 0;
    localparam int unsigned K_MSB     = 15;
    localparam int unsigned K_REQ_W   = K_MSB - K_LSB + 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EMIT    = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ECHO  = 2'd0,
        TOP_K = 2'd1,
        MM    = 2'd2
    } opcode_e;

endpackage

// File: rtl/top_k_insert_cell.sv
// One slot of the parallel insertion sorter; shifts in its left neighbour or the new value.
module top_k_insert_cell
    import top_k_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] v_i,
    input  logic [DATA_W-1:0] left_value_i,
    input  logic              left_vld_i,
    input  logic              left_ins_i,
    output logic [DATA_W-1:0] value_o,
    output logic              vld_o,
    output logic              ins_c_o
);

    logic [DATA_W-1:0] value_q, value_d;
    logic              vld_q, vld_d;

    // Strict compare so equal values keep the older entry ahead.
    assign ins_c_o = !vld_q || (v_i > value_q);
    assign value_o = value_q;
    assign vld_o   = vld_q;

    // Next slot contents: take the neighbour's entry if it moved down, else the new value.
    always_comb begin
        value_d = value_q;
        vld_d   = vld_q;
        if (clr_i) begin
            vld_d = 1'b0;
        end else if (en_i && ins_c_o) begin
            value_d = left_ins_i ? left_value_i : v_i;
            vld_d   = left_ins_i ? left_vld_i : 1'b1;
        end
    end

    // Slot storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: rtl/top_k_sorter.sv
// Running top-k sorter: collects a batch, then streams the k largest values out, largest first.
module top_k_sorter
    import top_k_pkg::*;
#(
    parameter int unsigned K_MAX = K_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [TDATA_W-1:0] s_TDATA,
    input  logic               s_TVALID,
    output logic               s_TREADY,
    output logic [DATA_W-1:0]  m_TDATA,
    output logic               m_TVALID,
    input  logic               m_TREADY,
    output logic               m_TLAST
);

    localparam int unsigned CNT_W = $clog2(K_MAX) + 1;
    localparam int unsigned IDX_W = $clog2(K_MAX);

    state_e             state_q;
    logic [CNT_W-1:0]   k_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   idx_q;
    logic               s_rdy_q;
    logic               m_vld_q;
    logic               m_last_q;
    logic [DATA_W-1:0]  m_data_q;

    logic [DATA_W-1:0]  slot_val [K_MAX];
    logic               slot_vld [K_MAX];
    logic               slot_ins [K_MAX];

    logic               acc_c, is_clr_c, is_last_c, ins_en_c, final_hs_c, slot_clr_c;
    logic [DATA_W-1:0]  value_c, sel_val_c, emit_val_c;
    logic [K_REQ_W-1:0] k_req_c;
    logic [CNT_W-1:0]   k_clamp_c, n_c, sel_idx_c;
    logic               sel_last_c;

    assign acc_c      = s_TVALID & s_rdy_q;
    assign is_clr_c   = s_TDATA[CLR_BIT];
    assign is_last_c  = s_TDATA[LAST_BIT];
    assign value_c    = s_TDATA[DATA_W-1:0];
    assign k_req_c    = s_TDATA[K_MSB:K_LSB];
    assign ins_en_c   = acc_c & ~is_clr_c;
    assign final_hs_c = (state_q == EMIT) & m_vld_q & m_TREADY & m_last_q;
    assign slot_clr_c = (acc_c & is_clr_c) | final_hs_c;

    // Clamp the full 16-bit request before narrowing it to the counter width.
    assign k_clamp_c  = ((k_req_c == '0) || (k_req_c > K_REQ_W'(K_MAX))) ? CNT_W'(K_MAX)
                                                                          : CNT_W'(k_req_c);
    assign n_c        = (k_q < cnt_q) ? k_q : cnt_q;

    // Slot to present next: current index on first load, following index on each handshake.
    assign sel_idx_c  = m_vld_q ? (idx_q + CNT_W'(1)) : idx_q;
    assign sel_val_c  = slot_val[IDX_W'(sel_idx_c)];
    assign sel_last_c = (n_c == '0) || (sel_idx_c == (n_c - CNT_W'(1)));
    assign emit_val_c = (n_c == '0) ? '0 : sel_val_c;

    // Insertion chain; slot 0 has no left neighbour.
    for (genvar i = 0; i < int'(K_MAX); i++) begin : g_slot
        logic [DATA_W-1:0] left_val;
        logic              left_vld;
        logic              left_ins;
        if (i == 0) begin : g_head
            assign left_val = '0;
            assign left_vld = 1'b0;
            assign left_ins = 1'b0;
        end else begin : g_link
            assign left_val = slot_val[i-1];
            assign left_vld = slot_vld[i-1];
            assign left_ins = slot_ins[i-1];
        end
        top_k_insert_cell u_cell (
            .clk          (clk),
            .rst          (rst),
            .en_i         (ins_en_c),
            .clr_i        (slot_clr_c),
            .v_i          (value_c),
            .left_value_i (left_val),
            .left_vld_i   (left_vld),
            .left_ins_i   (left_ins),
            .value_o      (slot_val[i]),
            .vld_o        (slot_vld[i]),
            .ins_c_o      (slot_ins[i])
        );
    end

    // Batch control FSM with registered stream outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= COLLECT;
            k_q      <= CNT_W'(K_MAX);
            cnt_q    <= '0;
            idx_q    <= '0;
            s_rdy_q  <= 1'b0;
            m_vld_q  <= 1'b0;
            m_last_q <= 1'b0;
            m_data_q <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    s_rdy_q <= 1'b1;
                    if (acc_c) begin
                        if (is_clr_c) begin
                            k_q   <= k_clamp_c;
                            cnt_q <= '0;
                        end else begin
                            if (cnt_q < CNT_W'(K_MAX)) begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                            if (is_last_c) begin
                                state_q <= EMIT;
                                s_rdy_q <= 1'b0;
                                idx_q   <= '0;
                            end
                        end
                    end
                end
                EMIT: begin
                    if (!m_vld_q) begin
                        m_vld_q  <= 1'b1;
                        m_data_q <= emit_val_c;
                        m_last_q <= sel_last_c;
                    end else if (m_TREADY) begin
                        if (m_last_q) begin
                            m_vld_q  <= 1'b0;
                            m_last_q <= 1'b0;
                            m_data_q <= '0;
                            idx_q    <= '0;
                            cnt_q    <= '0;
                            state_q  <= DRAIN;
                        end else begin
                            idx_q    <= sel_idx_c;
                            m_data_q <= emit_val_c;
                            m_last_q <= sel_last_c;
                        end
                    end
                end
                DRAIN: begin
                    s_rdy_q <= 1'b1;
                    state_q <= COLLECT;
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    assign s_TREADY = s_rdy_q;
    assign m_TVALID = m_vld_q;
    assign m_TLAST  = m_last_q;
    assign m_TDATA  = m_data_q;

endmodule
